// File: rtl/cmp_hyst_sched.sv
// cmp_hyst_sched: schedules per-channel hysteresis compares onto one shared
// IEEE-754 single comparator. A start latches all values and thresholds,
// issues one operand pair per cycle, tracks the in-flight results through a
// CMP_LAT-deep valid/index pipe, and commits every channel state at once
// together with a one-cycle done_sig pulse.
// Optional build macro: CMP_SCHED_THCHK_EN adds a per-channel threshold
// sanity compare (hi > lo) and the th_err output.

`ifndef SINGLE
`define SINGLE 32
`endif

module cmp_hyst_sched #(
    parameter int CH      = 4,
    parameter int W       = `SINGLE,
    parameter int CMP_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sta,
    input  logic [CH*W-1:0] val_in,
    input  logic [CH*W-1:0] hi_th,
    input  logic [CH*W-1:0] lo_th,
    output logic [W-1:0]    cmp_a,
    output logic [W-1:0]    cmp_b,
    input  logic            cmp_agb,
    input  logic            cmp_alb,
    output logic [CH-1:0]   state_out,
`ifdef CMP_SCHED_THCHK_EN
    output logic [CH-1:0]   th_err,
`endif
    output logic            busy,
    output logic            done_sig
);

`ifdef CMP_SCHED_THCHK_EN
    localparam int NSUB = 3;
`else
    localparam int NSUB = 2;
`endif
    localparam int              CH_W     = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [1:0]      LAST_SUB = 2'(NSUB - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CH*W-1:0] r_val;
    logic [CH*W-1:0] r_hi;
    logic [CH*W-1:0] r_lo;
    logic [CH_W-1:0] r_ch;
    logic [1:0]      r_sub;
    logic [W-1:0]    r_cmp_a;
    logic [W-1:0]    r_cmp_b;
    logic [W-1:0]    w_op_a;
    logic [W-1:0]    w_op_b;
    logic            r_pv   [CMP_LAT];
    logic [CH_W-1:0] r_pch  [CMP_LAT];
    logic [1:0]      r_psub [CMP_LAT];
    logic [CH-1:0]   r_gt;
    logic [CH-1:0]   r_lt;
    logic [CH-1:0]   r_state_out;
    logic [CH-1:0]   w_commit;
    logic            r_done;
    logic            w_accept;
    logic            w_last_issue;
    logic            w_cap_vld;
    logic [CH_W-1:0] w_cap_ch;
    logic [1:0]      w_cap_sub;
    logic            w_last_cap;
`ifdef CMP_SCHED_THCHK_EN
    logic [CH-1:0]   r_thok;
    logic [CH-1:0]   r_th_err;
`endif

    // A start is only honoured in IDLE; anything else (including FIN) drops it.
    assign w_accept     = (r_state == IDLE) && sta;
    assign w_last_issue = (r_state == ISSUE) && (r_ch == LAST_CH) && (r_sub == LAST_SUB);

    // The oldest pipe stage lines up with the comparator result on this cycle.
    assign w_cap_vld  = r_pv[CMP_LAT-1];
    assign w_cap_ch   = r_pch[CMP_LAT-1];
    assign w_cap_sub  = r_psub[CMP_LAT-1];
    assign w_last_cap = w_cap_vld && (w_cap_ch == LAST_CH) && (w_cap_sub == LAST_SUB);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every clocked register uses <= so all flops see pre-edge values.
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE:    if (sta)          w_next = ISSUE;
            ISSUE:   if (w_last_issue) w_next = DRAIN;
            DRAIN:   if (w_last_cap)   w_next = FIN;
            FIN:                       w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    // Operand pair selected by the issue counters (channel, sub-pair).
    always_comb begin
        w_op_a = r_val[r_ch*W +: W];
        w_op_b = r_hi[r_ch*W +: W];
        case (r_sub)
            2'd1: w_op_b = r_lo[r_ch*W +: W];
`ifdef CMP_SCHED_THCHK_EN
            2'd2: begin
                w_op_a = r_hi[r_ch*W +: W];
                w_op_b = r_lo[r_ch*W +: W];
            end
`endif
            default: ;
        endcase
    end

    // Input latch at start, then one registered operand pair per ISSUE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_val   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_ch    <= '0;
            r_sub   <= '0;
            r_cmp_a <= '0;
            r_cmp_b <= '0;
        end else if (w_accept) begin
            r_val <= val_in;
            r_hi  <= hi_th;
            r_lo  <= lo_th;
            r_ch  <= '0;
            r_sub <= '0;
        end else if (r_state == ISSUE) begin
            r_cmp_a <= w_op_a;
            r_cmp_b <= w_op_b;
            if (r_sub == LAST_SUB) begin
                r_sub <= '0;
                r_ch  <= r_ch + 1'b1;
            end else begin
                r_sub <= r_sub + 1'b1;
            end
        end
    end

    // Valid/index pipe tracking each issued pair until its result arrives.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the pipe array is reset so a mid-run reset leaves nothing in flight.
        if (!rst) begin
            for (int s = 0; s < CMP_LAT; s++) begin
                r_pv[s]   <= 1'b0;
                r_pch[s]  <= '0;
                r_psub[s] <= '0;
            end
        end else begin
            r_pv[0]   <= (r_state == ISSUE);
            r_pch[0]  <= r_ch;
            r_psub[0] <= r_sub;
            for (int s = 1; s < CMP_LAT; s++) begin
                r_pv[s]   <= r_pv[s-1];
                r_pch[s]  <= r_pch[s-1];
                r_psub[s] <= r_psub[s-1];
            end
        end
    end

    // Result capture: hi-compare keeps A>B, lo-compare keeps A<B.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gt <= '0;
            r_lt <= '0;
`ifdef CMP_SCHED_THCHK_EN
            r_thok <= '0;
`endif
        end else if (w_cap_vld) begin
            case (w_cap_sub)
                2'd0: r_gt[w_cap_ch] <= cmp_agb;
                2'd1: r_lt[w_cap_ch] <= cmp_alb;
`ifdef CMP_SCHED_THCHK_EN
                2'd2: r_thok[w_cap_ch] <= cmp_agb;
`endif
                default: ;
            endcase
        end
    end

    // Hysteresis update: set above hi, clear below lo, otherwise hold.
    always_comb begin
        w_commit = r_state_out;
        for (int i = 0; i < CH; i++) begin
            if (r_gt[i])      w_commit[i] = 1'b1;
            else if (r_lt[i]) w_commit[i] = 1'b0;
`ifdef CMP_SCHED_THCHK_EN
            // Inverted or equal thresholds make the decision meaningless.
            if (!r_thok[i]) w_commit[i] = r_state_out[i];
`endif
        end
    end

    // Commit all channels and pulse done in the FIN cycle's closing edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_out <= '0;
            r_done      <= 1'b0;
`ifdef CMP_SCHED_THCHK_EN
            r_th_err    <= '0;
`endif
        end else begin
            r_done <= (r_state == FIN);
            if (r_state == FIN) begin
                r_state_out <= w_commit;
`ifdef CMP_SCHED_THCHK_EN
                r_th_err    <= ~r_thok;
`endif
            end
        end
    end

    assign cmp_a     = r_cmp_a;
    assign cmp_b     = r_cmp_b;
    assign state_out = r_state_out;
    assign busy      = (r_state != IDLE);
    assign done_sig  = r_done;
`ifdef CMP_SCHED_THCHK_EN
    assign th_err    = r_th_err;
`endif

endmodule

// File: tb/tb_cmp_hyst_sched.sv
// tb_cmp_hyst_sched: directed bench for cmp_hyst_sched. Two instances share
// the value/threshold inputs: one with CMP_LAT=1 and one with CMP_LAT=3, each
// driven by its own behavioural float comparator. Edge E0 is the edge that
// samples sta high; all outputs are sampled 1 ns after a rising edge.

`timescale 1ns/1ps

module tb_cmp_hyst_sched;

    localparam int CH = 4;
    localparam int W  = 32;
`ifdef CMP_SCHED_THCHK_EN
    localparam int NSUB = 3;
`else
    localparam int NSUB = 2;
`endif
    localparam int P = NSUB * CH;

    localparam logic [W-1:0] F3  = 32'h4040_0000;
    localparam logic [W-1:0] F2  = 32'h4000_0000;
    localparam logic [W-1:0] F15 = 32'h3FC0_0000;
    localparam logic [W-1:0] F1  = 32'h3F80_0000;
    localparam logic [W-1:0] F05 = 32'h3F00_0000;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          sta_m;
    logic [CH*W-1:0]     val_in, hi_th, lo_th;
    logic [1:0][W-1:0]   cmp_a_m, cmp_b_m;
    logic [1:0][CH-1:0]  state_m;
    logic [1:0][CH-1:0]  therr_m;
    logic [1:0]          busy_m, done_m;
    logic                agb0, alb0, agb1, alb1;
    logic [1:0]          p3_gt, p3_lt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Ordered compare for IEEE-754 single (no NaN handling needed here).
    function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka, kb;
        ka = a[31] ? ~a : (a | 32'h8000_0000);
        kb = b[31] ? ~b : (b | 32'h8000_0000);
        return ka > kb;
    endfunction

    // Latency-1 comparator: result valid in the cycle after operands change.
    always_comb begin
        agb0 = f_gt(cmp_a_m[0], cmp_b_m[0]);
        alb0 = f_gt(cmp_b_m[0], cmp_a_m[0]);
    end

    // Latency-3 comparator: two extra register stages.
    always @(posedge clk) begin
        p3_gt <= {p3_gt[0], f_gt(cmp_a_m[1], cmp_b_m[1])};
        p3_lt <= {p3_lt[0], f_gt(cmp_b_m[1], cmp_a_m[1])};
    end
    assign agb1 = p3_gt[1];
    assign alb1 = p3_lt[1];

    cmp_hyst_sched #(.CH(CH), .W(W), .CMP_LAT(1)) u_dut_l1 (
        .clk       (clk),
        .rst       (rst),
        .sta       (sta_m[0]),
        .val_in    (val_in),
        .hi_th     (hi_th),
        .lo_th     (lo_th),
        .cmp_a     (cmp_a_m[0]),
        .cmp_b     (cmp_b_m[0]),
        .cmp_agb   (agb0),
        .cmp_alb   (alb0),
        .state_out (state_m[0]),
`ifdef CMP_SCHED_THCHK_EN
        .th_err    (therr_m[0]),
`endif
        .busy      (busy_m[0]),
        .done_sig  (done_m[0])
    );

    cmp_hyst_sched #(.CH(CH), .W(W), .CMP_LAT(3)) u_dut_l3 (
        .clk       (clk),
        .rst       (rst),
        .sta       (sta_m[1]),
        .val_in    (val_in),
        .hi_th     (hi_th),
        .lo_th     (lo_th),
        .cmp_a     (cmp_a_m[1]),
        .cmp_b     (cmp_b_m[1]),
        .cmp_agb   (agb1),
        .cmp_alb   (alb1),
        .state_out (state_m[1]),
`ifdef CMP_SCHED_THCHK_EN
        .th_err    (therr_m[1]),
`endif
        .busy      (busy_m[1]),
        .done_sig  (done_m[1])
    );

`ifndef CMP_SCHED_THCHK_EN
    assign therr_m = '0;
`endif

    task automatic set_ch(input int i, input logic [W-1:0] v, input logic [W-1:0] h,
                          input logic [W-1:0] l);
        val_in[i*W +: W] = v;
        hi_th[i*W +: W]  = h;
        lo_th[i*W +: W]  = l;
    endtask

    task automatic set_all(input logic [W-1:0] v, input logic [W-1:0] h, input logic [W-1:0] l);
        for (int i = 0; i < CH; i++) set_ch(i, v, h, l);
    endtask

    // Expected operand pair k from the inputs captured at E0.
    function automatic logic [2*W-1:0] exp_pair(input int k, input logic [CH*W-1:0] v,
                                                input logic [CH*W-1:0] h,
                                                input logic [CH*W-1:0] l);
        int c, s;
        c = k / NSUB;
        s = k % NSUB;
        case (s)
            0:       return {v[c*W +: W], h[c*W +: W]};
            1:       return {v[c*W +: W], l[c*W +: W]};
            default: return {h[c*W +: W], l[c*W +: W]};
        endcase
    endfunction

    // One full run on instance d. Inputs are scrambled right after E0 to show
    // they were latched. With poke set, sta is pulsed at E3 and in FIN.
    task automatic run(input int d, input logic [CH-1:0] exp_state, input bit poke,
                       input string tag);
        int lat, done_edge, last_e, done_cnt;
        bit state_stable, busy_ok;
        logic [CH*W-1:0] sv, sh, sl;
        logic [CH-1:0] prev, exp_th;
        logic [2*W-1:0] ep, last_pair;
        lat       = (d == 0) ? 1 : 3;
        done_edge = P + lat + 1;
        last_e    = done_edge + 3;
        done_cnt  = 0;
        state_stable = 1'b1;
        busy_ok   = 1'b1;
        last_pair = '0;
        @(negedge clk);
        sta_m[d] = 1'b1;
        @(posedge clk);
        #1;
        sta_m[d] = 1'b0;
        sv = val_in; sh = hi_th; sl = lo_th;
        prev = state_m[d];
        val_in = ~val_in; hi_th = ~hi_th; lo_th = ~lo_th;
        for (int i = 0; i < CH; i++) exp_th[i] = ~f_gt(sh[i*W +: W], sl[i*W +: W]);
        n_checks++;
        if (busy_m[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_E0: got %b want 1", tag, busy_m[d]);
        end
        for (int e = 1; e <= last_e; e++) begin
            @(posedge clk);
            #1;
            if (e <= P) begin
                ep = exp_pair(e - 1, sv, sh, sl);
                last_pair = ep;
                n_checks++;
                if ({cmp_a_m[d], cmp_b_m[d]} !== ep) begin
                    n_fail++;
                    $display("FAIL %s pair%0d at E%0d: got a=%h b=%h want a=%h b=%h", tag,
                             e - 1, e, cmp_a_m[d], cmp_b_m[d], ep[2*W-1:W], ep[W-1:0]);
                end
            end
            if (done_m[d] === 1'b1) begin
                done_cnt++;
                n_checks++;
                if (e != done_edge) begin
                    n_fail++;
                    $display("FAIL %s done_edge: got E%0d want E%0d", tag, e, done_edge);
                end
            end
            if (e < done_edge) begin
                if (state_m[d] !== prev) state_stable = 1'b0;
                if (busy_m[d] !== 1'b1)  busy_ok = 1'b0;
            end
            if (e == done_edge) begin
                n_checks++;
                if (state_m[d] !== exp_state) begin
                    n_fail++;
                    $display("FAIL %s state_out: got %b want %b", tag, state_m[d], exp_state);
                end
                n_checks++;
                if (busy_m[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s busy_at_done: got %b want 0", tag, busy_m[d]);
                end
`ifdef CMP_SCHED_THCHK_EN
                n_checks++;
                if (therr_m[d] !== exp_th) begin
                    n_fail++;
                    $display("FAIL %s th_err: got %b want %b", tag, therr_m[d], exp_th);
                end
`endif
            end
            if (e > done_edge && busy_m[d] !== 1'b0) busy_ok = 1'b0;
            if (poke && (e == 2 || e == P + lat))     sta_m[d] = 1'b1;
            if (poke && (e == 3 || e == P + lat + 1)) sta_m[d] = 1'b0;
        end
        n_checks++;
        if (!state_stable) begin
            n_fail++;
            $display("FAIL %s state_early_change: got changed want held until E%0d", tag, done_edge);
        end
        n_checks++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL %s busy_window: got wrong busy level want high E0..E%0d only", tag,
                     done_edge - 1);
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d want 1", tag, done_cnt);
        end
        n_checks++;
        if ({cmp_a_m[d], cmp_b_m[d]} !== last_pair) begin
            n_fail++;
            $display("FAIL %s cmp_hold: got a=%h b=%h want a=%h b=%h", tag, cmp_a_m[d],
                     cmp_b_m[d], last_pair[2*W-1:W], last_pair[W-1:0]);
        end
        n_checks++;
        if (state_m[d] !== exp_state) begin
            n_fail++;
            $display("FAIL %s state_after: got %b want %b", tag, state_m[d], exp_state);
        end
        val_in = sv; hi_th = sh; lo_th = sl;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        sta_m = '0;
        set_all(F3, F2, F1);
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({state_m[d], therr_m[d], busy_m[d], done_m[d], cmp_a_m[d], cmp_b_m[d]} !== '0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got st=%b te=%b busy=%b done=%b a=%h b=%h want all 0",
                         d, state_m[d], therr_m[d], busy_m[d], done_m[d], cmp_a_m[d], cmp_b_m[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_set();
        set_all(F3, F2, F1);
        run(0, 4'b1111, 1'b0, "set_l1");
    endtask

    task automatic test_hold_and_clear();
        set_all(F15, F2, F1);
        run(0, 4'b1111, 1'b0, "hold_l1");
        set_all(F05, F2, F1);
        run(0, 4'b0000, 1'b0, "clear_l1");
    endtask

    task automatic test_channel_map();
        set_ch(0, F3,  F2, F1);
        set_ch(1, F15, F2, F1);
        set_ch(2, F05, F2, F1);
        set_ch(3, F3,  F2, F1);
        run(1, 4'b1001, 1'b0, "map_l3_a");
        set_ch(0, F05, F2, F1);
        set_ch(1, F3,  F2, F1);
        set_ch(2, F15, F2, F1);
        set_ch(3, F15, F2, F1);
        run(1, 4'b1010, 1'b0, "map_l3_b");
    endtask

    task automatic test_sta_ignore();
        set_all(F3, F2, F1);
        run(0, 4'b1111, 1'b1, "sta_ignore_l1");
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        set_all(F05, F2, F1);
        @(negedge clk);
        sta_m[0] = 1'b1;
        @(posedge clk);
        #1;
        sta_m[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({state_m[0], therr_m[0], busy_m[0], done_m[0], cmp_a_m[0], cmp_b_m[0]} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got st=%b te=%b busy=%b done=%b a=%h b=%h want all 0",
                     state_m[0], therr_m[0], busy_m[0], done_m[0], cmp_a_m[0], cmp_b_m[0]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk);
            #1;
            if (done_m[0] === 1'b1 || busy_m[0] === 1'b1 || state_m[0] !== '0) done_cnt++;
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_resume: got %0d active cycles want 0", done_cnt);
        end
        set_all(F3, F2, F1);
        run(0, 4'b1111, 1'b0, "after_reset_l1");
        run(1, 4'b1111, 1'b0, "after_reset_l3");
    endtask

`ifdef CMP_SCHED_THCHK_EN
    task automatic test_thchk();
        set_all(F05, F2, F1);
        set_ch(2, F05, F1, F2);
        run(0, 4'b0100, 1'b0, "thchk_l1");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_set();
        test_hold_and_clear();
        test_channel_map();
        test_sta_ignore();
        test_reset_mid();
`ifdef CMP_SCHED_THCHK_EN
        test_thchk();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
